// File: rtl/timer_input_control_if.sv
// Keypad/timer bundle between the microwave keypad front end and its users.
// The front end drives D, LOAD_N and CLK_1HZ; the keypad side drives KPAD and EN_N.
interface timer_input_control_if;
  logic [9:0] KPAD;
  logic       EN_N;
  logic [3:0] D;
  logic       LOAD_N;
  logic       CLK_1HZ;

  modport master (
    output KPAD,
    output EN_N,
    input  D,
    input  LOAD_N,
    input  CLK_1HZ
  );

  modport slave (
    input  KPAD,
    input  EN_N,
    output D,
    output LOAD_N,
    output CLK_1HZ
  );
endinterface

// File: rtl/timer_input_control.sv
// Keypad sync/debounce/priority encode with load strobe, plus the 1 Hz divider.
// All state lives in the CLK_100HZ domain and clears on synchronous RST.
module timer_input_control #(
  parameter int DIV             = 100,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                  CLK_100HZ,
  input logic                  RST,
  timer_input_control_if.slave io
);
  localparam int HALF = DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(HALF - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [9:0]    s1_q, s2_q;
  logic [4:0]    key;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    acc_q, acc_d;
  logic          evt_q, evt_d;
  logic [3:0]    d_q, d_d;
  logic          load_n_q, load_n_d;
  logic [DW-1:0] div_q, div_d;
  logic          clk1_q, clk1_d;

  // {valid, code}; higher index overrides, so key 9 wins
  always_comb begin
    key = '0;
    for (int i = 0; i < 10; i++) begin
      if (s2_q[i]) key = {1'b1, 4'(i)};
    end
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (key != cand_q) begin
      cand_d = key;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CMAX) acc_d = cand_q;
    end
    evt_d = acc_d[4] && (acc_d != acc_q);
  end

  // Events seen while disabled are simply dropped
  always_comb begin
    load_n_d = 1'b1;
    d_d      = d_q;
    if (evt_q && !io.EN_N) begin
      load_n_d = 1'b0;
      d_d      = acc_q[3:0];
    end
  end

  always_comb begin
    div_d  = div_q + 1'b1;
    clk1_d = clk1_q;
    if (div_q == DMAX) begin
      div_d  = '0;
      clk1_d = !clk1_q;
    end
  end

  always_ff @(posedge CLK_100HZ) begin
    if (RST) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      evt_q    <= 1'b0;
      d_q      <= '0;
      load_n_q <= 1'b1;
      div_q    <= '0;
      clk1_q   <= 1'b0;
    end else begin
      s1_q     <= io.KPAD;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      evt_q    <= evt_d;
      d_q      <= d_d;
      load_n_q <= load_n_d;
      div_q    <= div_d;
      clk1_q   <= clk1_d;
    end
  end

  assign io.D       = d_q;
  assign io.LOAD_N  = load_n_q;
  assign io.CLK_1HZ = clk1_q;
endmodule

// File: tb/tb_timer_input_control.sv
// Directed bench for timer_input_control: divider timing, load strobes,
// priority, enable gating, glitch rejection and reset recovery.
module tb_timer_input_control;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   lows;
  int   first;
  int   run_len;
  int   max_run;
  int   ecnt;

  timer_input_control_if io ();

  timer_input_control #(
    .DIV            (100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK_100HZ(clk),
    .RST      (rst),
    .io       (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic clr();
    lows    = 0;
    first   = -1;
    run_len = 0;
    max_run = 0;
    ecnt    = 0;
  endtask

  // Advance n edges, sampling #1 after each, logging LOAD_N low cycles
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt++;
      if (io.LOAD_N == 1'b0) begin
        lows++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (first < 0) first = ecnt;
      end else begin
        run_len = 0;
      end
    end
  endtask

  task automatic press(input logic [9:0] k, input int n);
    io.KPAD = k;
    clr();
    run(n);
  endtask

  initial begin
    int rise1;
    int fall1;
    int rise2;
    logic prev;
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    io.KPAD = '0;
    io.EN_N = 1'b1;
    clr();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_D", int'(io.D), 0);
    chk("rst_LOAD_N", int'(io.LOAD_N), 1);
    chk("rst_CLK_1HZ", int'(io.CLK_1HZ), 0);
    rst = 1'b0;

    rise1 = -1;
    fall1 = -1;
    rise2 = -1;
    prev  = io.CLK_1HZ;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk);
      #1;
      if (e % 7 == 0) io.EN_N = ~io.EN_N;
      if (io.CLK_1HZ && !prev) begin
        if (rise1 < 0) rise1 = e;
        else if (rise2 < 0) rise2 = e;
      end
      if (!io.CLK_1HZ && prev && fall1 < 0) fall1 = e;
      prev = io.CLK_1HZ;
    end
    chk("div_rise1", rise1, 50);
    chk("div_fall1", fall1, 100);
    chk("div_period", rise2 - rise1, 100);

    io.EN_N = 1'b0;
    press(10'b0000000001, 100);
    chk("k0_pulses", lows, 1);
    chk("k0_width", max_run, 1);
    chk("k0_lat", first, 7);
    chk("k0_D", int'(io.D), 0);

    press(10'b0000010000, 100);
    chk("k4_pulses", lows, 1);
    chk("k4_lat", first, 7);
    chk("k4_D", int'(io.D), 4);

    press(10'b1000000000, 100);
    chk("k9_pulses", lows, 1);
    chk("k9_lat", first, 7);
    chk("k9_D", int'(io.D), 9);

    press(10'b0100000010, 100);
    chk("prio_pulses", lows, 1);
    chk("prio_D", int'(io.D), 8);

    press(10'b0000000000, 100);
    chk("rel_pulses", lows, 0);
    chk("rel_D", int'(io.D), 8);

    io.EN_N = 1'b1;
    clr();
    io.KPAD = 10'b0000000001;
    run(100);
    io.KPAD = 10'b0000010000;
    run(100);
    io.KPAD = 10'b1000000000;
    run(100);
    io.KPAD = 10'b0100000010;
    run(100);
    chk("dis_pulses", lows, 0);
    chk("dis_D", int'(io.D), 8);

    io.EN_N = 1'b0;
    clr();
    run(50);
    chk("held_pulses", lows, 0);

    press(10'b0000000000, 20);
    press(10'b0000000100, 100);
    chk("k2_pulses", lows, 1);
    chk("k2_lat", first, 7);
    chk("k2_D", int'(io.D), 2);

    press(10'b0000000000, 20);
    clr();
    io.KPAD = 10'b0000001000;
    run(2);
    io.KPAD = 10'b0000000000;
    run(50);
    chk("glitch_pulses", lows, 0);
    chk("glitch_D", int'(io.D), 2);

    press(10'b0000100000, 20);
    chk("k5_D", int'(io.D), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_D", int'(io.D), 0);
    chk("mid_rst_LOAD_N", int'(io.LOAD_N), 1);
    chk("mid_rst_CLK_1HZ", int'(io.CLK_1HZ), 0);
    clr();
    run(100);
    chk("reacc_pulses", lows, 1);
    chk("reacc_lat", first, 7);
    chk("reacc_D", int'(io.D), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_input_control.md
Name: timer_input_control

Overview:
- Keypad front end for the microwave timer.
- Synchronises and debounces a 10-key one-hot-ish keypad, then priority-encodes it to a BCD digit D.
- Issues a one-cycle active-low LOAD_N strobe toward the timer/counter chain for each accepted key press while enabled (EN_N low).
- Divides the 100 Hz system clock down to the 1 Hz count clock CLK_1HZ.

Parameters:
- DIV, 100, CLK_100HZ cycles per CLK_1HZ period. Even, ≥2.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised key code must stay stable before it is accepted. ≥1.

Ports:
- CLK_100HZ input 1: system clock; all logic on its rising edge.
- RST input 1: synchronous, active-high reset.
- KPAD input 10: asynchronous keypad lines; bit i high = key i pressed.
- EN_N input 1: active-low keypad enable.
- D output 4: BCD of the last accepted key, registered.
- LOAD_N output 1: active-low load strobe, registered.
- CLK_1HZ output 1: divided clock, 50% duty, registered.

Behaviour:
- Reset (RST high at a rising edge) sets all state to zero:
  - D=0, LOAD_N=1, CLK_1HZ=0.
  - Divider count=0.
  - Synchroniser flops, candidate, stability count and accepted code all cleared; accepted = "no key".
  - RST takes precedence over all other inputs.
- Synchroniser: KPAD passes through 2 flip-flop stages (s1, s2).
- Priority encoder on s2:
  - valid = OR of all bits.
  - code = index of the highest set bit (key 9 highest priority). Example: 10'b0100000010 -> 8.
  - code=0 when no key is pressed.
- Debounce:
  - Register cand = {valid, code} and a stability counter.
  - Each edge: if s2-derived {valid, code} differs from cand, cand loads it and the counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - Accepted takes cand on the edge where the counter reaches DEBOUNCE_CYCLES-1.
- Load event: accepted changes to a valid key from either "no key" or a different valid key.
  - Release (change to no key) is not an event.
  - A held key produces exactly one event.
- On the edge after a load event:
  - If EN_N=0 (sampled that edge): LOAD_N=0 for exactly one cycle, and D takes the accepted code on that same edge.
  - If EN_N=1: no strobe; LOAD_N stays 1 and D holds.
  - Events occurring while disabled are discarded, not queued.
- Otherwise LOAD_N=1 and D holds its value.
- Latency, default DEBOUNCE_CYCLES=4: LOAD_N goes low at the 7th rising edge after KPAD changes (DEBOUNCE_CYCLES+3 edges).
- Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produce no event.
- EN_N is used directly and is not synchronised (quasi-static control).
- Divider:
  - Counter runs 0..DIV/2-1 continuously, independent of EN_N and KPAD.
  - At terminal count, the counter wraps to 0 and CLK_1HZ toggles.
  - First CLK_1HZ rise occurs at the DIV/2-th edge after reset; period = DIV cycles.

Test Plan:
- Divider: RST for 2 cycles, then run 300 cycles -> CLK_1HZ rises at edge 50, falls at 100, period 100, and is unaffected by EN_N toggling.
- Single key enabled: EN_N=0, KPAD=10'b0000000001 held 100 cycles -> exactly one LOAD_N low pulse of 1 cycle, 7 edges after the change; D=0 from that edge onward.
- Key change enabled: from key 0, KPAD=10'b0000010000 held 100 cycles, then 10'b1000000000 -> one pulse each, D=4 then D=9.
- Priority: EN_N=0, KPAD=10'b0100000010 -> one pulse, D=8. Then KPAD=0 -> no pulse, D stays 8.
- Disabled: EN_N=1, apply keys 0, 4, 9, then 8+1 (100 cycles each) -> LOAD_N constantly 1, D holds 8. Then EN_N=0 with key still held -> no pulse until a new press.
- Debounce/reset: 2-cycle KPAD=10'b0000001000 glitch -> no pulse. Assert RST during a held key -> D=0, LOAD_N=1, CLK_1HZ=0. The still-held key is re-accepted after release of RST, giving one pulse 7 edges later.
